// File: rtl/sfp_link_pkg.sv
// sfp_link_pkg
//   Shared definitions for the SFP link controller:
//   - link_state_e : FSM state encoding, also driven out on o_state
//   - Def*         : default timing constants for a 40 MHz clock
//   - max3         : helper used to size the shared state-duration counter
package sfp_link_pkg;

    typedef enum logic [2:0] {
        StOff     = 3'd0,
        StInit    = 3'd1,
        StRun     = 3'd2,
        StFault   = 3'd3,
        StLockout = 3'd4
    } link_state_e;

    localparam int unsigned DefInitCyc   = 12000000; // 300 ms
    localparam int unsigned DefResetCyc  = 800;      // 20 us
    localparam int unsigned DefStableCyc = 40000;    // 1 ms
    localparam int unsigned DefMaxRetry  = 3;
    localparam int unsigned DefMaxOnCyc  = 8000;     // 200 us
    localparam int unsigned DefMinOffCyc = 400;      // 10 us

    function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sfp_link_ctrl_if.sv
// sfp_link_ctrl_if
//   Board-side signal bundle of the SFP link controller.
//   Inputs : i_enable, i_fault_clr, i_sfp_tx_flt, i_sfp_loss_sig, i_pls_req
//   Outputs: o_pls_gated, o_sfp_tx_dis_n, o_drv_en, o_link_ok, o_rx_ok,
//            o_fault_latched, o_retry_cnt[1:0], o_state[2:0]
//   slave  : controller side, master : board / bench side.
interface sfp_link_ctrl_if;

    logic       i_enable;
    logic       i_fault_clr;
    logic       i_sfp_tx_flt;
    logic       i_sfp_loss_sig;
    logic       i_pls_req;
    logic       o_pls_gated;
    logic       o_sfp_tx_dis_n;
    logic       o_drv_en;
    logic       o_link_ok;
    logic       o_rx_ok;
    logic       o_fault_latched;
    logic [1:0] o_retry_cnt;
    logic [2:0] o_state;

    modport master (
        output i_enable, i_fault_clr, i_sfp_tx_flt, i_sfp_loss_sig, i_pls_req,
        input  o_pls_gated, o_sfp_tx_dis_n, o_drv_en, o_link_ok, o_rx_ok,
               o_fault_latched, o_retry_cnt, o_state
    );

    modport slave (
        input  i_enable, i_fault_clr, i_sfp_tx_flt, i_sfp_loss_sig, i_pls_req,
        output o_pls_gated, o_sfp_tx_dis_n, o_drv_en, o_link_ok, o_rx_ok,
               o_fault_latched, o_retry_cnt, o_state
    );

endinterface

// File: rtl/pls_limiter.sv
// pls_limiter
//   Pulse gate between the synchronized interrupter request and the serial
//   transmitter. A pulse starts on a request rising edge seen while running,
//   is cut after MAX_ON_CYC cycles, and is followed by at least MIN_OFF_CYC
//   low cycles.
//   i_clk       : system clock
//   i_res_n     : synchronous active-low reset
//   i_req_s     : synchronized request
//   i_run_en    : link is (about to be) in RUN, aligned with the state register
//   o_pls_gated : registered gated pulse
module pls_limiter #(
    parameter int unsigned MAX_ON_CYC  = 8000,
    parameter int unsigned MIN_OFF_CYC = 400
) (
    input  logic i_clk,
    input  logic i_res_n,
    input  logic i_req_s,
    input  logic i_run_en,
    output logic o_pls_gated
);

    localparam int unsigned OnW  = $clog2(MAX_ON_CYC + 1);
    localparam int unsigned OffW = $clog2(MIN_OFF_CYC + 1);
    localparam logic [OnW-1:0]  OnMax   = OnW'(MAX_ON_CYC);
    // Load value gives MIN_OFF_CYC low cycles including the one where the count hits zero.
    localparam logic [OffW-1:0] OffLoad = OffW'(MIN_OFF_CYC - 1);

    logic            gated_q, gated_d;
    logic            arm_q, arm_d;
    logic [OnW-1:0]  on_cnt_q, on_cnt_d;
    logic [OffW-1:0] off_rem_q, off_rem_d;

    always_comb begin
        gated_d   = gated_q;
        on_cnt_d  = on_cnt_q;
        off_rem_d = (off_rem_q != '0) ? off_rem_q - OffW'(1) : off_rem_q;
        arm_d     = arm_q;

        // Armed only by a low request seen while running, so a request already
        // high at RUN entry (or still high after truncation) cannot start a pulse.
        if (!i_run_en) begin
            arm_d = 1'b0;
        end else if (!i_req_s) begin
            arm_d = 1'b1;
        end

        if (gated_q) begin
            if (i_run_en && i_req_s && (on_cnt_q != OnMax)) begin
                on_cnt_d = on_cnt_q + OnW'(1);
            end else begin
                gated_d   = 1'b0;
                on_cnt_d  = '0;
                off_rem_d = OffLoad;
            end
        end else if (i_run_en && i_req_s && arm_q && (off_rem_q == '0)) begin
            gated_d  = 1'b1;
            on_cnt_d = OnW'(1);
            arm_d    = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_res_n) begin
            gated_q   <= 1'b0;
            arm_q     <= 1'b0;
            on_cnt_q  <= '0;
            off_rem_q <= '0;
        end else begin
            gated_q   <= gated_d;
            arm_q     <= arm_d;
            on_cnt_q  <= on_cnt_d;
            off_rem_q <= off_rem_d;
        end
    end

    assign o_pls_gated = gated_q;

endmodule

// File: rtl/sfp_link_ctrl.sv
// sfp_link_ctrl
//   SFP transmit sequencer and safety gate: TX_DISABLE release, init wait,
//   TX_FAULT retry with a TX_DISABLE reset pulse, lockout after repeated
//   faults, and the interrupter pulse gate (pls_limiter).
//   i_clk   : 40 MHz system clock
//   i_res_n : synchronous active-low reset
//   bus     : sfp_link_ctrl_if.slave, board inputs and registered outputs
module sfp_link_ctrl
    import sfp_link_pkg::*;
#(
    parameter int unsigned T_INIT_CYC   = DefInitCyc,
    parameter int unsigned T_RESET_CYC  = DefResetCyc,
    parameter int unsigned T_STABLE_CYC = DefStableCyc,
    parameter int unsigned MAX_RETRY    = DefMaxRetry,
    parameter int unsigned MAX_ON_CYC   = DefMaxOnCyc,
    parameter int unsigned MIN_OFF_CYC  = DefMinOffCyc
) (
    input logic              i_clk,
    input logic              i_res_n,
    sfp_link_ctrl_if.slave   bus
);

    // One counter times every state; it restarts at each state change and saturates.
    localparam int unsigned CntTop = max3(T_INIT_CYC, T_RESET_CYC, T_STABLE_CYC) - 1;
    localparam int unsigned CntW   = $clog2(CntTop + 2);
    localparam logic [CntW-1:0] InitLast   = CntW'(T_INIT_CYC - 1);
    localparam logic [CntW-1:0] ResetLast  = CntW'(T_RESET_CYC - 1);
    localparam logic [CntW-1:0] StableLast = CntW'(T_STABLE_CYC - 1);
    localparam logic [CntW-1:0] CntMax     = CntW'(CntTop);
    localparam logic [1:0]      MaxRetry   = 2'(MAX_RETRY);

    link_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      retry_q, retry_d, retry_inc;

    logic flt_meta_q, flt_s_q;
    logic req_meta_q, req_s_q;
    logic loss_meta_q, rx_ok_q;
    logic tx_dis_n_q, drv_en_q, link_ok_q, latched_q;
    logic run_en;
    logic pls_gated;

    always_ff @(posedge i_clk) begin
        if (!i_res_n) begin
            flt_meta_q <= 1'b0;
            flt_s_q    <= 1'b0;
            req_meta_q <= 1'b0;
            req_s_q    <= 1'b0;
        end else begin
            flt_meta_q <= bus.i_sfp_tx_flt;
            flt_s_q    <= flt_meta_q;
            req_meta_q <= bus.i_pls_req;
            req_s_q    <= req_meta_q;
        end
    end

    // LOS status keeps tracking through reset; the second stage holds ~LOS directly.
    always_ff @(posedge i_clk) begin
        loss_meta_q <= bus.i_sfp_loss_sig;
        rx_ok_q     <= ~loss_meta_q;
    end

    assign retry_inc = (retry_q < MaxRetry) ? retry_q + 2'd1 : retry_q;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;

        unique case (state_q)
            StOff: begin
                if (bus.i_enable) state_d = StInit;
            end
            StInit: begin
                if (!bus.i_enable) begin
                    state_d = StOff;
                    retry_d = '0;
                end else if (cnt_q == InitLast) begin
                    if (flt_s_q) begin
                        state_d = StFault;
                        retry_d = retry_inc;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (!bus.i_enable) begin
                    state_d = StOff;
                    retry_d = '0;
                end else if (flt_s_q) begin
                    state_d = StFault;
                    retry_d = retry_inc;
                end else if (cnt_q >= StableLast) begin
                    retry_d = '0;
                end
            end
            StFault: begin
                if (!bus.i_enable) begin
                    state_d = StOff;
                    retry_d = '0;
                end else if (cnt_q == ResetLast) begin
                    state_d = (retry_q == MaxRetry) ? StLockout : StInit;
                end
            end
            StLockout: begin
                if (bus.i_fault_clr) begin
                    state_d = StOff;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = StOff;
                retry_d = '0;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Outputs decode the next state so they change on the same edge as state_q.
    always_ff @(posedge i_clk) begin
        if (!i_res_n) begin
            state_q    <= StOff;
            cnt_q      <= '0;
            retry_q    <= '0;
            tx_dis_n_q <= 1'b0;
            drv_en_q   <= 1'b0;
            link_ok_q  <= 1'b0;
            latched_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            tx_dis_n_q <= (state_d == StInit) || (state_d == StRun);
            drv_en_q   <= (state_d == StRun);
            link_ok_q  <= (state_d == StRun);
            latched_q  <= (state_d == StLockout);
        end
    end

    assign run_en = (state_d == StRun);

    pls_limiter #(
        .MAX_ON_CYC  (MAX_ON_CYC),
        .MIN_OFF_CYC (MIN_OFF_CYC)
    ) u_pls_limiter (
        .i_clk       (i_clk),
        .i_res_n     (i_res_n),
        .i_req_s     (req_s_q),
        .i_run_en    (run_en),
        .o_pls_gated (pls_gated)
    );

    assign bus.o_pls_gated     = pls_gated;
    assign bus.o_sfp_tx_dis_n  = tx_dis_n_q;
    assign bus.o_drv_en        = drv_en_q;
    assign bus.o_link_ok       = link_ok_q;
    assign bus.o_rx_ok         = rx_ok_q;
    assign bus.o_fault_latched = latched_q;
    assign bus.o_retry_cnt     = retry_q;
    assign bus.o_state         = state_q;

endmodule
